// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Data-memory bus between the load/store unit and data memory.
//   master (LSU side) : drives dmem_req, dmem_we, dmem_addr, dmem_wdata,
//                       dmem_be; samples dmem_gnt, dmem_rvalid, dmem_rdata
//   slave  (memory)   : the mirror image
// dmem_req/gnt form the request handshake; dmem_rvalid qualifies dmem_rdata,
// arriving at least one cycle after the grant of a read.
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
    parameter int addr_data_width = 32
);
    logic                       dmem_req;
    logic                       dmem_we;
    logic [addr_data_width-1:0] dmem_addr;
    logic [addr_data_width-1:0] dmem_wdata;
    logic [3:0]                 dmem_be;
    logic                       dmem_gnt;
    logic                       dmem_rvalid;
    logic [addr_data_width-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory stage after the ALU: runs one RV32I load/store per request on the
// data-memory bus and stalls the core until the access completes.
// Ports:
//   clk1, reset1       clock, asynchronous active-high reset
//   lsu_req            request, held with operands stable until lsu_done
//   lsu_we             1 = store, 0 = load
//   funct3             RV32I width/sign field
//   addr, store_data   effective byte address, rs2 data
//   load_data          formatted load result (registered, holds until next load)
//   lsu_done           one-cycle completion pulse
//   lsu_busy           stall to core
//   lsu_err            one-cycle pulse on misaligned access or illegal funct3
//   dmem               data-memory bus (master side)
// ---------------------------------------------------------------------------
module load_store_unit #(
    parameter int addr_data_width = 32
) (
    input  logic                       clk1,
    input  logic                       reset1,
    input  logic                       lsu_req,
    input  logic                       lsu_we,
    input  logic [2:0]                 funct3,
    input  logic [addr_data_width-1:0] addr,
    input  logic [addr_data_width-1:0] store_data,
    output logic [addr_data_width-1:0] load_data,
    output logic                       lsu_done,
    output logic                       lsu_busy,
    output logic                       lsu_err,
    load_store_unit_if.master          dmem
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT_R, DONE, ERR} state_e;

    state_e                     state_q, state_d;
    logic [addr_data_width-1:0] addr_q, addr_d;
    logic [addr_data_width-1:0] wdata_q, wdata_d;
    logic [addr_data_width-1:0] load_data_q, load_data_d;
    logic [3:0]                 be_q, be_d;
    logic                       we_q, we_d;
    logic [2:0]                 funct3_q, funct3_d;
    logic [1:0]                 off_q, off_d;

    logic                       legal, misaligned;
    logic [3:0]                 be_new;
    logic [addr_data_width-1:0] wdata_new;
    logic [addr_data_width-1:0] load_fmt;
    logic [7:0]                 byte_sel;
    logic [15:0]                half_sel;

    // Request decode: legality, alignment, lane enables and replicated data
    always_comb begin
        legal      = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = store_data;
        case (funct3)
            3'b000, 3'b001, 3'b010: legal = 1'b1;
            3'b100, 3'b101:         legal = ~lsu_we;
            default:                legal = 1'b0;
        endcase
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                misaligned = addr[0];
                be_new     = 4'b0011 << {addr[1], 1'b0};
                wdata_new  = {2{store_data[15:0]}};
            end
            default: misaligned = (addr[1:0] != 2'b00);
        endcase
    end

    // Load formatting from the lane latched at request time
    always_comb begin
        case (off_q)
            2'b00:   byte_sel = dmem.dmem_rdata[7:0];
            2'b01:   byte_sel = dmem.dmem_rdata[15:8];
            2'b10:   byte_sel = dmem.dmem_rdata[23:16];
            default: byte_sel = dmem.dmem_rdata[31:24];
        endcase
        half_sel = off_q[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_fmt = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_fmt = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_fmt = {24'd0, byte_sel};
            3'b101:  load_fmt = {16'd0, half_sel};
            default: load_fmt = dmem.dmem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk1 or posedge reset1) begin
        if (reset1) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            load_data_q <= '0;
            be_q        <= '0;
            we_q        <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            load_data_q <= load_data_d;
            be_q        <= be_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
        end
    end

    // Next-state logic; bus registers only load on IDLE -> REQ so they stay
    // stable for the whole request phase
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        be_d        = be_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        case (state_q)
            IDLE: begin
                if (lsu_req) begin
                    if (!legal || misaligned) begin
                        state_d = ERR;
                    end else begin
                        state_d  = REQ;
                        addr_d   = {addr[addr_data_width-1:2], 2'b00};
                        wdata_d  = wdata_new;
                        be_d     = be_new;
                        we_d     = lsu_we;
                        funct3_d = funct3;
                        off_d    = addr[1:0];
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_gnt) state_d = we_q ? DONE : WAIT_R;
            end
            WAIT_R: begin
                if (dmem.dmem_rvalid) begin
                    state_d     = DONE;
                    load_data_d = load_fmt;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        dmem.dmem_req   = (state_q == REQ);
        dmem.dmem_we    = we_q;
        dmem.dmem_addr  = addr_q;
        dmem.dmem_wdata = wdata_q;
        dmem.dmem_be    = be_q;
        lsu_done        = (state_q == DONE) || (state_q == ERR);
        lsu_err         = (state_q == ERR);
        lsu_busy        = lsu_req & ~lsu_done;
        load_data       = load_data_q;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_load_store_unit
// Self-checking bench for load_store_unit: fixed vector table, back-to-back
// and reset-in-flight sequences, then random operations against a byte-lane
// reference model. Inputs change on the falling edge; outputs are sampled
// 1 ns after the falling edge.
// ---------------------------------------------------------------------------
module tb_load_store_unit;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] rd;
        int          gd;     // REQ cycles before gnt (0 = immediate)
        int          rdd;    // cycles from gnt to rvalid (>= 1)
        logic        e_err;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_ld;
        int          e_lat;  // cycles from request to lsu_done
    } vec_t;

    logic        clk1 = 1'b0;
    logic        reset1;
    logic        lsu_req, lsu_we;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data, load_data;
    logic        lsu_done, lsu_busy, lsu_err;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] model_ld;
    vec_t        tbl[12];

    load_store_unit_if #(.addr_data_width(32)) dmem();

    load_store_unit #(.addr_data_width(32)) dut (
        .clk1       (clk1),
        .reset1     (reset1),
        .lsu_req    (lsu_req),
        .lsu_we     (lsu_we),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .lsu_done   (lsu_done),
        .lsu_busy   (lsu_busy),
        .lsu_err    (lsu_err),
        .dmem       (dmem)
    );

    always #5 clk1 = ~clk1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Reference model: works lane by lane from access size and byte offset
    function automatic vec_t model(input vec_t v, input logic [31:0] ld_prev);
        vec_t        r;
        int          sz, off;
        logic        legal;
        logic [63:0] val;
        r     = v;
        legal = v.we ? (v.f3 inside {3'd0, 3'd1, 3'd2})
                     : (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        sz    = 1 << v.f3[1:0];
        off   = int'(v.a[1:0]);
        r.e_err  = !legal || ((off % sz) != 0);
        r.e_addr = v.a & ~32'h3;
        r.e_be   = '0;
        r.e_wd   = '0;
        val      = '0;
        for (int i = 0; i < 4; i++) begin
            if (i >= off && i < off + sz) r.e_be[i] = 1'b1;
            r.e_wd[8*i +: 8] = v.sd[8*(i % sz) +: 8];
        end
        for (int j = 0; j < 4; j++)
            if (j < sz && off + j < 4) val[8*j +: 8] = v.rd[8*(off+j) +: 8];
        if (!v.f3[2] && sz < 4 && val[8*sz-1]) val = val | ~((64'd1 << (8*sz)) - 64'd1);
        r.e_ld  = (r.e_err || v.we) ? ld_prev : val[31:0];
        r.e_lat = r.e_err ? 1 : (v.we ? 2 + v.gd : 2 + v.gd + v.rdd);
        return r;
    endfunction

    // One complete operation with a simple memory responder. With keep set the
    // request stays high after lsu_done so the next call forms a back-to-back op.
    task automatic run_op(input vec_t v, input logic keep, input string tag);
        int          k, done_k, kg, nreq;
        logic        got_err, busy_bad, unstable, extra;
        logic [31:0] b_addr, b_wd, ld_at_done;
        logic [3:0]  b_be;
        logic        b_we;
        k = 0; done_k = -1; kg = -1; nreq = 0;
        got_err = 0; busy_bad = 0; unstable = 0; extra = 0;
        b_addr = '0; b_wd = '0; b_be = '0; b_we = 0; ld_at_done = '0;
        @(negedge clk1);
        lsu_req = 1; lsu_we = v.we; funct3 = v.f3; addr = v.a; store_data = v.sd;
        while (k < 64) begin
            #1;
            if (lsu_done) begin
                done_k = k; got_err = lsu_err; ld_at_done = load_data;
                if (lsu_busy) busy_bad = 1;
            end else if (!lsu_busy) busy_bad = 1;
            if (dmem.dmem_req) begin
                if (nreq == 0) begin
                    b_addr = dmem.dmem_addr; b_wd = dmem.dmem_wdata;
                    b_be = dmem.dmem_be; b_we = dmem.dmem_we;
                end else if (b_addr !== dmem.dmem_addr || b_wd !== dmem.dmem_wdata ||
                             b_be !== dmem.dmem_be || b_we !== dmem.dmem_we) begin
                    unstable = 1;
                end
                nreq++;
            end
            dmem.dmem_gnt = dmem.dmem_req && (nreq == v.gd + 1);
            if (dmem.dmem_gnt) kg = k;
            dmem.dmem_rvalid = (kg >= 0) && (k == kg + v.rdd);
            dmem.dmem_rdata  = dmem.dmem_rvalid ? v.rd : $urandom;
            if (done_k >= 0) break;
            @(negedge clk1);
            k++;
        end
        if (!keep) begin
            lsu_req = 0;
            repeat (2) begin
                @(negedge clk1);
                dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0;
                #1;
                if (lsu_done || dmem.dmem_req) extra = 1;
            end
            chk({tag, ".extra_done"}, 32'(extra), 32'd0);
        end
        chk({tag, ".latency"}, done_k, v.e_lat);
        chk({tag, ".err"}, 32'(got_err), 32'(v.e_err));
        chk({tag, ".busy"}, 32'(busy_bad), 32'd0);
        chk({tag, ".load_data"}, ld_at_done, v.e_ld);
        if (v.e_err) begin
            chk({tag, ".req_cycles"}, nreq, 0);
        end else begin
            chk({tag, ".req_cycles"}, nreq, v.gd + 1);
            chk({tag, ".addr"}, b_addr, v.e_addr);
            chk({tag, ".be"}, 32'(b_be), 32'(v.e_be));
            chk({tag, ".we"}, 32'(b_we), 32'(v.we));
            chk({tag, ".stable"}, 32'(unstable), 32'd0);
            if (v.we) chk({tag, ".wdata"}, b_wd, v.e_wd);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".dmem_req"}, 32'(dmem.dmem_req), 32'd0);
        chk({tag, ".dmem_we"}, 32'(dmem.dmem_we), 32'd0);
        chk({tag, ".dmem_addr"}, dmem.dmem_addr, 32'd0);
        chk({tag, ".dmem_wdata"}, dmem.dmem_wdata, 32'd0);
        chk({tag, ".dmem_be"}, 32'(dmem.dmem_be), 32'd0);
        chk({tag, ".lsu_done"}, 32'(lsu_done), 32'd0);
        chk({tag, ".lsu_err"}, 32'(lsu_err), 32'd0);
        chk({tag, ".load_data"}, load_data, 32'd0);
    endtask

    initial begin
        vec_t v, w;
        logic any_done, any_req;

        // we  f3      addr      sdata         rdata        gd rdd err addr      be     wdata         load_data     lat
        tbl[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        0, 1, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, 32'h00000000, 2};
        tbl[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h8A000000, 0, 1, 1'b0, 32'h10, 4'h8, 32'h0,        32'hFFFFFF8A, 3};
        tbl[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h8A000000, 1, 2, 1'b0, 32'h10, 4'h8, 32'h0,        32'h0000008A, 5};
        tbl[3]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h8A000000, 0, 1, 1'b0, 32'h10, 4'hC, 32'h0,        32'h00008A00, 3};
        tbl[4]  = '{1'b1, 3'b001, 32'h22, 32'h1234ABCD, 32'h0,        2, 1, 1'b0, 32'h20, 4'hC, 32'hABCDABCD, 32'h00008A00, 4};
        tbl[5]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,  4'h0, 32'h0,        32'h00008A00, 1};
        tbl[6]  = '{1'b1, 3'b100, 32'h10, 32'h55,       32'h0,        0, 1, 1'b1, 32'h0,  4'h0, 32'h0,        32'h00008A00, 1};
        tbl[7]  = '{1'b0, 3'b010, 32'h40, 32'h0,        32'hCAFEF00D, 3, 2, 1'b0, 32'h40, 4'hF, 32'h0,        32'hCAFEF00D, 7};
        tbl[8]  = '{1'b0, 3'b001, 32'h42, 32'h0,        32'h80011234, 1, 1, 1'b0, 32'h40, 4'hC, 32'h0,        32'hFFFF8001, 4};
        tbl[9]  = '{1'b1, 3'b000, 32'h31, 32'h3C3C3C5A, 32'h0,        0, 1, 1'b0, 32'h30, 4'h2, 32'h5A5A5A5A, 32'hFFFF8001, 2};
        tbl[10] = '{1'b0, 3'b001, 32'h03, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,  4'h0, 32'h0,        32'hFFFF8001, 1};
        tbl[11] = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        0, 1, 1'b1, 32'h0,  4'h0, 32'h0,        32'hFFFF8001, 1};

        reset1 = 1; lsu_req = 0; lsu_we = 0; funct3 = '0; addr = '0; store_data = '0;
        dmem.dmem_gnt = 0; dmem.dmem_rvalid = 0; dmem.dmem_rdata = '0;
        repeat (2) @(negedge clk1);
        #1;
        chk_all_zero("reset");
        chk("reset.lsu_busy", 32'(lsu_busy), 32'd0);
        reset1 = 0;

        for (int i = 0; i < 12; i++) begin
            run_op(tbl[i], 1'b0, $sformatf("tbl%0d", i));
            model_ld = tbl[i].e_ld;
        end

        // Back-to-back: request held across DONE with new operands
        v = '{1'b1, 3'b010, 32'h100, 32'h11223344, 32'h0, 0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        w = model(v, model_ld);
        run_op(w, 1'b1, "b2b_a");
        model_ld = w.e_ld;
        v = '{1'b0, 3'b100, 32'h101, 32'h0, 32'h0000AB00, 0, 1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h0, 0};
        w = model(v, model_ld);
        chk("b2b_b.model_ld", w.e_ld, 32'h000000AB);
        run_op(w, 1'b0, "b2b_b");
        model_ld = w.e_ld;

        // Randomized operations against the reference model
        for (int i = 0; i < 200; i++) begin
            v.we  = 1'($urandom_range(0, 1));
            v.f3  = 3'($urandom_range(0, 7));
            v.a   = $urandom;
            v.sd  = $urandom;
            v.rd  = $urandom;
            v.gd  = int'($urandom_range(0, 3));
            v.rdd = int'($urandom_range(1, 3));
            w = model(v, model_ld);
            run_op(w, (i != 199) && ($urandom_range(0, 1) == 1), $sformatf("rnd%0d", i));
            model_ld = w.e_ld;
        end

        // Reset while waiting for read data; late rvalid/gnt must be ignored
        @(negedge clk1);
        lsu_req = 1; lsu_we = 0; funct3 = 3'b010; addr = 32'h50; store_data = '0;
        @(negedge clk1);
        #1;
        chk("rst_mid.req_seen", 32'(dmem.dmem_req), 32'd1);
        dmem.dmem_gnt = 1;
        @(negedge clk1);
        #1;
        dmem.dmem_gnt = 0;
        chk("rst_mid.in_wait", 32'(dmem.dmem_req), 32'd0);
        reset1 = 1;
        #1;
        chk_all_zero("rst_mid.during");
        reset1 = 0;
        lsu_req = 0;
        dmem.dmem_rvalid = 1; dmem.dmem_gnt = 1; dmem.dmem_rdata = 32'h12345678;
        any_done = 0; any_req = 0;
        repeat (3) begin
            @(negedge clk1);
            #1;
            if (lsu_done) any_done = 1;
            if (dmem.dmem_req) any_req = 1;
            dmem.dmem_rvalid = 0; dmem.dmem_gnt = 0;
        end
        chk("rst_mid.no_done", 32'(any_done), 32'd0);
        chk("rst_mid.no_req", 32'(any_req), 32'd0);
        chk_all_zero("rst_mid.after");

        model_ld = '0;
        w = model(tbl[0], model_ld);
        run_op(w, 1'b0, "post_reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
